// File: rtl/jtframe_mc2_dataio.sv
// rtl/jtframe_mc2_dataio.sv - SPI data-I/O receiver feeding the ioctl ROM download port
module jtframe_mc2_dataio #(
  parameter int ADDR_W     = 22,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_data,
  output logic              ioctl_wr,
  output logic [7:0]        ioctl_index,
  output logic              downloading,
  output logic              dl_done
);

  localparam logic [ADDR_W-1:0] LP_START = ADDR_W'(START_ADDR);

  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_DATA  = 8'h54;
  localparam logic [7:0] CMD_INDEX = 8'h55;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_START_ARG,
    ST_DATA,
    ST_INDEX_ARG,
    ST_IGNORE
  } state_t;

  logic              r_sck_s1, r_sck_s2, r_sck_s3;
  logic              r_ss_s1, r_ss_s2;
  logic              r_di_s1, r_di_s2;
  logic [7:0]        r_shift;
  logic [2:0]        r_bitcnt;
  logic              r_byte_vld;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_wr;
  logic [7:0]        r_index;
  logic              r_dl;
  logic              r_dl_prev;
  logic              r_done;
  logic              w_sck_rise;

  assign w_sck_rise  = r_sck_s2 & ~r_sck_s3;

  assign ioctl_addr  = r_addr;
  assign ioctl_data  = r_data;
  assign ioctl_wr    = r_wr;
  assign ioctl_index = r_index;
  assign downloading = r_dl;
  assign dl_done     = r_done;

  // Bring the SPI pins into the clk domain; third SCK flop gives the rise detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_s3 <= 1'b0;
      r_ss_s1  <= 1'b0;
      r_ss_s2  <= 1'b0;
      r_di_s1  <= 1'b0;
      r_di_s2  <= 1'b0;
    end else begin
      r_sck_s1 <= SPI_SCK;
      r_sck_s2 <= r_sck_s1;
      r_sck_s3 <= r_sck_s2;
      r_ss_s1  <= SPI_SS2;
      r_ss_s2  <= r_ss_s1;
      r_di_s1  <= SPI_DI;
      r_di_s2  <= r_di_s1;
    end
  end

  // Assemble MSB-first bytes; a deselect drops any partial byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= 8'd0;
      r_bitcnt   <= 3'd0;
      r_byte_vld <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      if (r_ss_s2) begin
        r_bitcnt <= 3'd0;
      end else if (w_sck_rise) begin
        r_shift    <= {r_shift[6:0], r_di_s2};
        r_bitcnt   <= r_bitcnt + 3'd1;
        r_byte_vld <= (r_bitcnt == 3'd7);
      end
    end
  end

  // Command decoder and ioctl outputs; address advances the cycle after each strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CMD;
      r_addr    <= '0;
      r_data    <= 8'd0;
      r_wr      <= 1'b0;
      r_index   <= 8'd0;
      r_dl      <= 1'b0;
      r_dl_prev <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wr      <= 1'b0;
      r_dl_prev <= r_dl;
      r_done    <= r_dl_prev & ~r_dl;
      if (r_wr) begin
        r_addr <= r_addr + 1'b1;
      end
      if (r_byte_vld) begin
        case (r_state)
          ST_CMD: begin
            if (r_shift == CMD_START)      r_state <= ST_START_ARG;
            else if (r_shift == CMD_DATA)  r_state <= ST_DATA;
            else if (r_shift == CMD_INDEX) r_state <= ST_INDEX_ARG;
            else                           r_state <= ST_IGNORE;
          end
          ST_START_ARG: begin
            if (r_shift != 8'd0) begin
              r_dl   <= 1'b1;
              r_addr <= LP_START;
            end else begin
              r_dl   <= 1'b0;
            end
            r_state <= ST_IGNORE;
          end
          ST_DATA: begin
            if (r_dl) begin
              r_data <= r_shift;
              r_wr   <= 1'b1;
            end
          end
          ST_INDEX_ARG: begin
            r_index <= r_shift;
            r_state <= ST_IGNORE;
          end
          default: r_state <= ST_IGNORE;
        endcase
      end
      if (r_ss_s2) begin
        r_state <= ST_CMD;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_mc2_dataio.sv
// tb/tb_jtframe_mc2_dataio.sv - randomized frame-level bench for jtframe_mc2_dataio
module tb_jtframe_mc2_dataio;

  localparam int A_W     = 22;
  localparam int A_START = 32'h100;
  localparam int B_W     = 4;
  localparam int B_START = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic ss2 = 1'b1;
  logic di  = 1'b0;

  logic [A_W-1:0] a_addr;
  logic [7:0]     a_data, a_index;
  logic           a_wr, a_dl, a_done;
  logic [B_W-1:0] b_addr;
  logic [7:0]     b_data, b_index;
  logic           b_wr, b_dl, b_done;

  always #5 clk = ~clk;

  jtframe_mc2_dataio #(.ADDR_W(A_W), .START_ADDR(A_START)) u_dut_a (
    .clk(clk), .rst(rst), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .ioctl_addr(a_addr), .ioctl_data(a_data), .ioctl_wr(a_wr),
    .ioctl_index(a_index), .downloading(a_dl), .dl_done(a_done)
  );

  jtframe_mc2_dataio #(.ADDR_W(B_W), .START_ADDR(B_START)) u_dut_b (
    .clk(clk), .rst(rst), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .ioctl_addr(b_addr), .ioctl_data(b_data), .ioctl_wr(b_wr),
    .ioctl_index(b_index), .downloading(b_dl), .dl_done(b_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // observed write strobes and done pulses
  int   act_a[$];
  int   act_b[$];
  int   done_a = 0, done_b = 0, dbl_wr = 0;
  logic pa = 1'b0, pb = 1'b0;

  always @(negedge clk) begin
    if (a_wr) act_a.push_back(int'(a_addr) * 256 + int'(a_data));
    if (b_wr) act_b.push_back(int'(b_addr) * 256 + int'(b_data));
    if ((a_wr && pa) || (b_wr && pb)) dbl_wr <= dbl_wr + 1;
    if (a_done) done_a <= done_a + 1;
    if (b_done) done_b <= done_b + 1;
    pa <= a_wr;
    pb <= b_wr;
  end

  // reference model: frame-level interpretation of the protocol
  logic [7:0] tx[$];
  int   exp_a[$];
  int   exp_b[$];
  bit   m_dl = 0;
  int   m_index = 0, m_addr_a = 0, m_addr_b = 0, m_done = 0;

  task automatic model_frame(input int nbytes);
    if (nbytes < 1) return;
    if (tx[0] == 8'h53) begin
      if (nbytes >= 2) begin
        if (tx[1] != 8'h00) begin
          m_dl     = 1;
          m_addr_a = A_START % (1 << A_W);
          m_addr_b = B_START % (1 << B_W);
        end else begin
          if (m_dl) m_done++;
          m_dl = 0;
        end
      end
    end else if (tx[0] == 8'h54) begin
      for (int i = 1; i < nbytes; i++) begin
        if (m_dl) begin
          exp_a.push_back(m_addr_a * 256 + int'(tx[i]));
          exp_b.push_back(m_addr_b * 256 + int'(tx[i]));
          m_addr_a = (m_addr_a + 1) % (1 << A_W);
          m_addr_b = (m_addr_b + 1) % (1 << B_W);
        end
      end
    end else if (tx[0] == 8'h55) begin
      if (nbytes >= 2) m_index = int'(tx[1]);
    end
  endtask

  task automatic model_reset();
    m_dl = 0; m_index = 0; m_addr_a = 0; m_addr_b = 0;
  endtask

  task automatic compare(input string tag);
    chk({tag, ".nwr_a"}, act_a.size(), exp_a.size());
    chk({tag, ".nwr_b"}, act_b.size(), exp_b.size());
    for (int i = 0; i < act_a.size() && i < exp_a.size(); i++)
      chk($sformatf("%s.wr_a%0d", tag, i), act_a[i], exp_a[i]);
    for (int i = 0; i < act_b.size() && i < exp_b.size(); i++)
      chk($sformatf("%s.wr_b%0d", tag, i), act_b[i], exp_b[i]);
    chk({tag, ".dl_a"},    a_dl, m_dl);
    chk({tag, ".dl_b"},    b_dl, m_dl);
    chk({tag, ".idx_a"},   a_index, m_index);
    chk({tag, ".idx_b"},   b_index, m_index);
    chk({tag, ".addr_a"},  a_addr, m_addr_a);
    chk({tag, ".addr_b"},  b_addr, m_addr_b);
    chk({tag, ".done_a"},  done_a, m_done);
    chk({tag, ".done_b"},  done_b, m_done);
    act_a.delete(); act_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".a"}, {a_addr, a_data, a_wr, a_index, a_dl, a_done}, 0);
    chk({tag, ".b"}, {b_addr, b_data, b_wr, b_index, b_dl, b_done}, 0);
  endtask

  // send tx as one SS2 frame; trunc_bits>0 cuts the last byte short, rst_bit>=0 pulses reset there
  task automatic send_frame(input string tag, input int half, input int trunc_bits, input int rst_bit);
    int nbits;
    logic [7:0] cur;
    nbits = tx.size() * 8;
    if (trunc_bits > 0) nbits = (tx.size() - 1) * 8 + trunc_bits;
    @(negedge clk);
    ss2 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      cur = tx[i / 8];
      di  = cur[7 - (i % 8)];
      sck = 1'b0;
      repeat (half) @(negedge clk);
      sck = 1'b1;
      if (i == rst_bit) begin
        model_frame(i / 8);
        model_reset();
        #3 rst = 1'b1;
        #1 check_zero({tag, ".rst_now"});
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      repeat (half) @(negedge clk);
    end
    sck = 1'b0;
    repeat (half) @(negedge clk);
    ss2 = 1'b1;
    repeat (12) @(negedge clk);
    if (rst_bit < 0) model_frame(trunc_bits > 0 ? tx.size() - 1 : tx.size());
    compare(tag);
  endtask

  task automatic frame2(input string tag, input logic [7:0] c, input logic [7:0] arg);
    tx.delete(); tx.push_back(c); tx.push_back(arg);
    send_frame(tag, 4, 0, -1);
  endtask

  task automatic data_frame(input string tag, input int n, input int half);
    tx.delete(); tx.push_back(8'h54);
    for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
    send_frame(tag, half, 0, -1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // basic download of AA 55 C3
    frame2("start1", 8'h53, 8'h01);
    tx.delete(); tx.push_back(8'h54); tx.push_back(8'hAA); tx.push_back(8'h55); tx.push_back(8'hC3);
    send_frame("data3", 4, 0, -1);
    frame2("stop1", 8'h53, 8'h00);

    // index then two-byte download
    frame2("index07", 8'h55, 8'h07);
    frame2("start2", 8'h53, 8'h01);
    data_frame("data2", 2, 3);
    frame2("stop2", 8'h53, 8'h00);

    // partial byte dropped, then 54 11
    frame2("start3", 8'h53, 8'h02);
    tx.delete(); tx.push_back(8'h54); tx.push_back(8'($urandom));
    send_frame("partial", 4, 5, -1);
    frame2("data11", 8'h54, 8'h11);
    frame2("stop3", 8'h53, 8'h00);

    // data while idle and unknown command
    frame2("idle_ff", 8'h54, 8'hFF);
    tx.delete(); tx.push_back(8'h99); tx.push_back(8'h54); tx.push_back(8'h12);
    send_frame("unk99", 4, 0, -1);
    frame2("idle_stop", 8'h53, 8'h00);

    // 17 bytes wraps the 4-bit address, then fastest SCK rate
    frame2("start4", 8'h53, 8'h01);
    data_frame("wrap17", 17, 4);
    data_frame("fast", 6, 2);
    frame2("restart", 8'h53, 8'h7F);
    data_frame("after_restart", 3, 2);

    // random frames
    for (int f = 0; f < 30; f++) begin
      int r, half;
      r    = $urandom_range(0, 9);
      half = $urandom_range(2, 5);
      tx.delete();
      if (r <= 2) begin
        tx.push_back(8'h53);
        tx.push_back($urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'h00);
      end else if (r <= 6) begin
        tx.push_back(8'h54);
        for (int i = 0; i < $urandom_range(1, 5); i++) tx.push_back(8'($urandom));
      end else if (r == 7) begin
        tx.push_back(8'h55);
        tx.push_back(8'($urandom));
      end else begin
        tx.push_back(8'($urandom));
        for (int i = 0; i < $urandom_range(0, 3); i++) tx.push_back(8'($urandom));
      end
      send_frame($sformatf("rnd%0d", f), half, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0, -1);
    end

    // reset during the 4th byte of a data frame
    frame2("start5", 8'h53, 8'h01);
    tx.delete(); tx.push_back(8'h54);
    for (int i = 0; i < 3; i++) tx.push_back(8'($urandom));
    send_frame("rst_mid", 4, 0, 27);
    data_frame("post_rst", 3, 3);
    frame2("start6", 8'h53, 8'h01);
    data_frame("post_rst_dl", 2, 3);

    chk("dbl_wr", dbl_wr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtframe_mc2_dataio.md
JTFRAME_MC2_DATAIO -- requirements
Module: jtframe_mc2_dataio

Interface
REQ-001 Parameter ADDR_W, default 22, width of ioctl_addr.
REQ-002 Parameter START_ADDR, default 0, first address written after a download start.
REQ-003 clk  input  1  system clock (clk_rom domain); the block has one clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 SPI_SCK  input  1  SPI clock from the STM32 I/O controller, asynchronous to clk.
REQ-006 SPI_SS2  input  1  data-I/O frame select, active low, asynchronous.
REQ-007 SPI_DI  input  1  SPI serial data in (controller to FPGA), MSB first, sampled on the SCK rising edge.
REQ-008 ioctl_addr  output  ADDR_W  byte address associated with the current ioctl_wr pulse.
REQ-009 ioctl_data  output  8  received ROM byte.
REQ-010 ioctl_wr  output  1  one-clk write strobe for ioctl_addr/ioctl_data.
REQ-011 ioctl_index  output  8  file index from the last index command.
REQ-012 downloading  output  1  high while a ROM download is in progress.
REQ-013 dl_done  output  1  one-clk pulse when downloading falls.

Function
REQ-014 SPI_SCK, SPI_SS2 and SPI_DI each pass through a 2-flop synchroniser; a third SCK flop provides rising-edge detect (sync2=1, sync3=0).
REQ-015 clk frequency is at least 4x SCK; slower clocks are unsupported and not checked.
REQ-016 A bit is shifted into an 8-bit shift register on each detected SCK rise while synchronised SS2 is low; a 3-bit counter tracks bit position.
REQ-017 The byte is complete in the cycle the 8th bit is shifted; the byte handler acts in the following cycle.
REQ-018 Synchronised SS2 high clears the bit counter and returns the FSM to CMD, discarding any partial byte; it does not change downloading, ioctl_addr or ioctl_index.
REQ-019 FSM states: CMD, START_ARG, DATA, INDEX_ARG, IGNORE.
- CMD: byte 0x53 -> START_ARG; 0x54 -> DATA; 0x55 -> INDEX_ARG; any other byte -> IGNORE.
- START_ARG: nonzero byte -> downloading=1, ioctl_addr=START_ADDR; zero byte -> downloading=0. Either byte -> IGNORE.
- DATA: each byte, when downloading=1 -> ioctl_data=byte, ioctl_wr=1 for exactly one clk; remain in DATA. When downloading=0, the byte is dropped with no strobe.
- INDEX_ARG: byte -> ioctl_index; -> IGNORE.
- IGNORE: consume bytes with no effect until SS2 goes high.
REQ-020 ioctl_addr and ioctl_data are stable during the ioctl_wr cycle; ioctl_addr increments by 1 in the cycle after ioctl_wr.
REQ-021 ioctl_addr wraps from 2^ADDR_W-1 to 0 without error.
REQ-022 START_ARG nonzero while already downloading restarts: ioctl_addr reloads START_ADDR and downloading stays 1.
REQ-023 dl_done pulses for exactly one clk in the cycle after downloading goes 1->0; a zero start argument while idle produces no pulse.
REQ-024 Back-to-back bytes at 4 clk per SCK period produce back-to-back ioctl_wr pulses with no loss; ioctl_wr is never high in two consecutive cycles.

Reset
REQ-025 While rst is high, all outputs, the synchronisers, the shift register and the bit counter are 0 and the FSM is CMD; ioctl_addr resets to 0, not START_ADDR.
REQ-026 rst asserted mid-byte or mid-download aborts it: downloading=0, no dl_done pulse, and no ioctl_wr until a new 0x53 nonzero start.
REQ-027 Deassertion of rst is synchronous to clk in the surrounding reset logic; the block needs no further reset handling.

Verification
REQ-028 Frame 53 01, frame 54 AA 55 C3, frame 53 00 -> ioctl_wr three pulses, (addr,data) = (0,AA),(1,55),(2,C3); downloading 1->0; dl_done one pulse.
REQ-029 START_ADDR=0x100, frame 55 07, then a full download of 2 bytes -> ioctl_index=07; writes at 0x100 and 0x101.
REQ-030 SS2 raised after 5 bits of a data byte, then new frame 54 11 -> no strobe for the partial byte; a single write of 0x11 at the next address.
REQ-031 Frame 54 FF with downloading=0, and frame 99 54 12 -> no ioctl_wr at all; ioctl_addr unchanged.
REQ-032 ADDR_W=4: download 17 bytes -> addresses 0..15 then 0; downloading remains 1.
REQ-033 rst pulse during the 4th byte of a data frame -> outputs 0 immediately (asynchronous); no further strobes for the remaining SCK edges of that frame.
